// File: rtl/nba_merge_pkg.sv
// Shared types and helpers for the nba_merge_reg register bank.
// Holds the commit FSM state encoding and the lane-to-bit mask expansion.
package nba_merge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Widest channel register the expansion helper supports; callers truncate to WIDTH.
    localparam int MAX_WIDTH = 128;
    localparam int MAX_IDX_W = $clog2(MAX_WIDTH);

    function automatic logic [MAX_WIDTH-1:0] lane_expand(input logic [MAX_WIDTH-1:0] mask,
                                                         input int                   lane);
        logic [MAX_WIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            bits[MAX_IDX_W'(i)] = mask[MAX_IDX_W'(i / lane)];
        end
        return bits;
    endfunction

endpackage

// File: rtl/nba_merge_lane_mux.sv
// Next pending value for one channel: folds every accepted write port into the
// current pending lanes, later ports overriding earlier ones lane by lane.
module nba_merge_lane_mux #(
    parameter int WIDTH  = 8,
    parameter int LANE   = 4,
    parameter int NPORTS = 2,
    parameter int CW     = 1,
    parameter int CHAN   = 0,
    localparam int NLANES = WIDTH / LANE
) (
    input  logic [NPORTS-1:0]        wr_en_i,
    input  logic [NPORTS*CW-1:0]     wr_chan_i,
    input  logic [NPORTS*WIDTH-1:0]  wr_data_i,
    input  logic [NPORTS*NLANES-1:0] wr_lmask_i,
    input  logic [WIDTH-1:0]         pend_data_i,
    input  logic [NLANES-1:0]        pend_mask_i,
    output logic [WIDTH-1:0]         pend_data_o,
    output logic [NLANES-1:0]        pend_mask_o
);

    // Ascending port order gives the highest port the final word on a lane.
    // Out-of-range channel indices never match any CHAN and are dropped.
    always_comb begin
        pend_data_o = pend_data_i;
        pend_mask_o = pend_mask_i;
        for (int p = 0; p < NPORTS; p++) begin
            if (wr_en_i[p] && (wr_chan_i[p*CW +: CW] == CW'(CHAN))) begin
                for (int l = 0; l < NLANES; l++) begin
                    if (wr_lmask_i[p*NLANES + l]) begin
                        pend_data_o[l*LANE +: LANE] = wr_data_i[p*WIDTH + l*LANE +: LANE];
                        pend_mask_o[l]              = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/nba_merge_reg.sv
// Register bank with deferred lane-masked writes: writes merge into a pending
// buffer while idle and are applied one channel per cycle on commit.
module nba_merge_reg
    import nba_merge_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANE   = 4,
    parameter int NCHAN  = 2,
    parameter int NPORTS = 2,
    localparam int NLANES = WIDTH / LANE,
    localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NPORTS-1:0]         wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [NPORTS*CW-1:0]      wr_chan_i,
    input  logic [NPORTS*WIDTH-1:0]   wr_data_i,
    input  logic [NPORTS*NLANES-1:0]  wr_lmask_i,
    input  logic                      commit_req_i,
    output logic                      commit_ack_o,
    output logic                      busy_o,
    output logic [NCHAN*WIDTH-1:0]    q_o,
    output logic [NCHAN*NLANES-1:0]   pend_mask_o,
    output logic [15:0]               commit_cnt_o
);

    state_e              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]    q_q       [NCHAN];
    logic [WIDTH-1:0]    q_d       [NCHAN];
    logic [WIDTH-1:0]    pend_q    [NCHAN];
    logic [WIDTH-1:0]    pend_d    [NCHAN];
    logic [NLANES-1:0]   pmask_q   [NCHAN];
    logic [NLANES-1:0]   pmask_d   [NCHAN];
    logic [WIDTH-1:0]    merge_data[NCHAN];
    logic [NLANES-1:0]   merge_mask[NCHAN];
    logic [WIDTH-1:0]    emask;
    logic                idle;
    logic [NPORTS-1:0]   wr_accept;

    assign idle      = (state_q == IDLE);
    assign wr_accept = wr_valid_i & {NPORTS{idle}};

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        nba_merge_lane_mux #(
            .WIDTH  (WIDTH),
            .LANE   (LANE),
            .NPORTS (NPORTS),
            .CW     (CW),
            .CHAN   (c)
        ) u_lane_mux (
            .wr_en_i     (wr_accept),
            .wr_chan_i   (wr_chan_i),
            .wr_data_i   (wr_data_i),
            .wr_lmask_i  (wr_lmask_i),
            .pend_data_i (pend_q[c]),
            .pend_mask_i (pmask_q[c]),
            .pend_data_o (merge_data[c]),
            .pend_mask_o (merge_mask[c])
        );

        assign q_o[c*WIDTH +: WIDTH]          = q_q[c];
        assign pend_mask_o[c*NLANES +: NLANES] = pmask_q[c];
    end

    assign wr_ready_o   = idle;
    assign busy_o       = (state_q == COMMIT) || (state_q == DONE);
    assign commit_ack_o = (state_q == DONE);
    assign commit_cnt_o = cnt_q;

    // Same-cycle writes are merged before a commit request takes effect, so they
    // are part of the commit. COMMIT scans one channel per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        pend_d  = pend_q;
        pmask_d = pmask_q;
        emask   = '0;
        unique case (state_q)
            IDLE: begin
                pend_d  = merge_data;
                pmask_d = merge_mask;
                if (commit_req_i) begin
                    state_d = COMMIT;
                    idx_d   = '0;
                end
            end
            COMMIT: begin
                for (int c = 0; c < NCHAN; c++) begin
                    if (idx_q == CW'(c)) begin
                        emask      = WIDTH'(lane_expand(MAX_WIDTH'(pmask_q[c]), LANE));
                        q_d[c]     = (q_q[c] & ~emask) | (pend_q[c] & emask);
                        pend_d[c]  = '0;
                        pmask_d[c] = '0;
                    end
                end
                if (idx_q == CW'(NCHAN - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            DONE: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                q_q[c]     <= '0;
                pend_q[c]  <= '0;
                pmask_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            for (int c = 0; c < NCHAN; c++) begin
                q_q[c]     <= q_d[c];
                pend_q[c]  <= pend_d[c];
                pmask_q[c] <= pmask_d[c];
            end
        end
    end

endmodule

// File: doc/nba_merge_reg.md
Name: nba_merge_reg

Overview:
- Parametrised bank of NCHAN registers with deferred, lane-masked writes and "last write wins" ordering.
- Writes accumulate in a pending buffer across any number of cycles, then are applied together on a commit handshake.
- This is the hardware model of non-blocking assignment semantics, including whole and partial updates to the same variable separated by suspend points.
- Used by timing regression benches as a golden reference for mixed whole/partial NBA ordering.

Parameters:
- WIDTH, 8: bits per channel register; must be a multiple of LANE.
- LANE, 4: bits per lane, the write-mask granularity. NLANES = WIDTH/LANE.
- NCHAN, 2: number of channel registers; must be at least 1. CW = max(1, $clog2(NCHAN)).
- NPORTS, 2: number of write ports; port index sets same-cycle order.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  NPORTS  per-port write request.
- wr_ready  out  1  high only in IDLE; a write is accepted when wr_valid[p] && wr_ready.
- wr_chan  in  NPORTS*CW  target channel per port.
- wr_data  in  NPORTS*WIDTH  write data per port.
- wr_lmask  in  NPORTS*NLANES  lane enables per port; all ones is a whole-variable write.
- commit_req  in  1  request to apply pending writes; sampled only in IDLE.
- commit_ack  out  1  one-cycle pulse when a commit completes.
- busy  out  1  high in COMMIT and DONE.
- q  out  NCHAN*WIDTH  committed values, channel 0 in the LSBs.
- pend_mask  out  NCHAN*NLANES  pending lane flags per channel.
- commit_cnt  out  16  completed commits, wraps at 2^16.

Behaviour:
- Reset (async assert, sync release): q=0, pending data=0, pend_mask=0, commit_cnt=0, state IDLE, commit_ack=0, busy=0, scan index=0.
- Pending merge, IDLE only:
  - Accepted writes are processed in ascending port index.
  - For each lane with the mask bit set: pending lane = data lane and pend flag = 1.
  - A higher port index overrides a lower one on the same channel and lane.
  - Writes in a later cycle override earlier pending lanes, whether the earlier write was whole or partial.
  - Lanes whose mask bit is clear keep their earlier pending value and flag.
  - A zero mask is accepted with no effect.
- States:
  - IDLE: wr_ready=1. When commit_req=1, writes accepted in the same cycle are merged first (they precede the commit). Next state COMMIT, scan index=0.
  - COMMIT: wr_ready=0. Each cycle, for channel idx: q[idx] = (q[idx] & ~expand(pmask)) | (pend & expand(pmask)). Then clear that channel's pend_mask and pending data. If idx == NCHAN-1, go to DONE; otherwise idx++. COMMIT lasts exactly NCHAN cycles.
  - DONE: commit_ack=1 for this single cycle, commit_cnt++, go to IDLE.
- Latency: commit_req sampled at edge k; q fully updated after edge k+NCHAN; commit_ack high between edges k+NCHAN and k+NCHAN+1.
- commit_req outside IDLE is ignored; it is not queued.
- A commit with no pending lanes still runs the full sequence and leaves q unchanged.
- Writes offered while wr_ready=0 are not accepted and have no side effects. Senders must hold them.
- Channels not yet scanned keep their old q value while COMMIT is in progress.
- Reset asserted mid-commit: everything clears to reset values, no commit_ack, and commit_cnt is not incremented.
- Channel index >= NCHAN: write dropped, no state change.

Decomposition:
- Package nba_merge_pkg holds the state enum (IDLE, COMMIT, DONE) and a function lane_expand(mask) -> bit mask.
- Sub-module nba_merge_lane_mux computes the combinational per-channel next-pending value across the ports, in priority order.
- The top level holds the pending and committed storage, the FSM and the counter.

Test Plan:
- Whole then partial (NCHAN=2): cycle 1 write ch0 data 0xFF mask 11; cycle 4 write ch0 data 0x00 mask 01; commit -> q[0]=0xF0, ack after 3 cycles, commit_cnt=1.
- Partial then whole: write ch1 data 0x00 mask 01; 3 idle cycles; write ch1 data 0xFF mask 11; commit -> q[1]=0xFF, pend_mask all zero after ack.
- Same-cycle conflict: port0 ch0 0x12 mask 11, port1 ch0 0xAB mask 01, same cycle; commit -> q[0]=0x1B (q starts at 0).
- Write with commit_req in the same IDLE cycle: ch0 0x5A mask 11 plus commit_req -> q[0]=0x5A. A write held through COMMIT is accepted in the cycle after ack and appears only in pend_mask.
- Reset mid-commit: pend ch0=0x33 and ch1=0x44; commit_req; drop rst_n during the second COMMIT cycle -> q=0, pend_mask=0, commit_cnt=0, no ack pulse.
- Empty commit and counter wrap: commit with nothing pending leaves q unchanged. Preload 0xFFFF commits -> the next commit wraps commit_cnt to 0.
